mc_controller: RTL
==================

# mc_controller

Multicycle control unit for the ARM-subset processor. It replaces the single-cycle decoder with an FSM that sequences each instruction over 3–5 cycles on a shared memory and ALU. It adds conditional execution against an internal NZCV flag register, plus new data-processing ops (EOR, CMP). It sits between the instruction register/flag outputs of the datapath and all datapath mux selects and write enables.

## Interface
- `ALU_CTRL_W`, default 3: ALUControl width. Must be ≥3. Codes are zero-extended.
- `HAS_CMP`, default 1: when 1, decode CMP (funct 1010, S=1) as SUB without writeback. When 0, funct 1010 is an unsupported op.
- `CLK` input 1: clock, rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `Instr` input 32: instruction register contents. Cond[31:28], Op[27:26], I[25], Funct[24:21], S/L[20].
- `ALUFlags` input 4: {N,Z,C,V} from the ALU in the current cycle.
- `PCWrite` output 1: PC load enable.
- `IRWrite` output 1: instruction register load enable.
- `MemWrite` output 1: data memory write enable.
- `RegWrite` output 1: register file write enable.
- `AdrSrc` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `ResultSrc` output 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` output 2: 00 = RD1 reg, 01 = PC, 10 = ALUOut.
- `ALUSrcB` output 2: 00 = RD2 reg, 01 = ExtImm, 10 = constant 4.
- `ImmSrc` output 2: equals Op (00 DP imm8, 01 mem imm12, 10 branch imm24).
- `RegSrc` output 2: bit0 = branch (Rn←R15), bit1 = STR (Rm←Rd).
- `ALUControl` output ALU_CTRL_W: ADD=0, SUB=1, AND=2, ORR=3, EOR=4.
- `State` output 4: current FSM state, for debug and coverage.

## Operation
- **FETCH:** IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1. Next state is DECODE.
- **DECODE:** ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10 (PC+8 onto R15). Next state by Op/I:
  - Op=01 → MEMADR
  - Op=00 with I=0 → EXECUTER
  - Op=00 with I=1 → EXECUTEI
  - Op=10 → BRANCH
  - Op=11 → FETCH (treated as NOP)
- **MEMADR:** ALUSrcA=00, ALUSrcB=01, ADD. Next state is MEMREAD if L=1, else MEMWRITE.
- **MEMREAD:** AdrSrc=1. Next state is MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=CondEx. Next state is FETCH.
- **MEMWRITE:** AdrSrc=1, MemWrite=CondEx. Next state is FETCH.
- **EXECUTER / EXECUTEI:** ALUSrcA=00, ALUSrcB=00 or 01 respectively, ALUControl from Funct. Next state is ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=CondEx & ~NoWrite. Next state is FETCH.
- **BRANCH:** ALUSrcA=10, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx. Next state is FETCH.
- **Funct decode:** 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1010 CMP (SUB with NoWrite=1, requires S=1).
- **Unsupported Funct:** ALUControl=ADD, NoWrite=1, FlagW=00.
- **FlagW:** when S=1, ADD/SUB/CMP set FlagW=11; AND/ORR/EOR set FlagW=10. bit1 updates NZ, bit0 updates CV.
- **CondEx:** evaluated from the registered flags against Cond, covering all 15 ARM codes with AL=1110. Cond=1111 gives CondEx=0.
- **Flag register update:** at the end of EXECUTER or EXECUTEI, if CondEx, each FlagW-selected half is loaded from ALUFlags. No other state writes the flags.
- Outputs not listed for a state are 0. ImmSrc and RegSrc are driven from Instr in every state.

## Timing
- Reset asynchronously forces State=FETCH and Flags=0000.
- While Reset is high, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. All other outputs take their FETCH values.
- After Reset deasserts, the first FETCH occurs on the next rising edge.
- All outputs are combinational (Moore on State, plus CondEx and Instr).
- Cycles per instruction: B = 3, DP = 4, STR = 4, LDR = 5, Op=11 = 2.
- A flag write in cycle t is visible to CondEx of any later instruction. It is not visible within the same instruction.
- Reset mid-instruction abandons the instruction. No MemWrite or RegWrite is issued once Reset is high, and flags clear.
- Instr must be stable from DECODE through the last state of the instruction. Only FETCH may change it, via IRWrite.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - state enum (4-bit)
  - ALU op codes
  - Cond codes
  - ResultSrc, ALUSrcA and ALUSrcB encodings
- Sub-module `cond_logic`: holds the 4-bit flag register and FlagW gating, and produces CondEx from Cond. Its ports are CLK, Reset, Cond, ALUFlags, FlagW and FlagUpd; its output is CondEx.
- Top level contains the FSM, the output decode and the Funct decoder.

## Test plan
- **ADDS with overflow:** Reset, then 0xE0910002 with ALUFlags=0001. Expected: states FETCH→DECODE→EXECUTER→ALUWB, RegWrite=1 in ALUWB, then Flags=0001.
- **CMP then BEQ:** CMP Z-result (ALUFlags=0100), then 0x0A000002. Expected: BRANCH asserts PCWrite=1. Repeat with ALUFlags=0000: PCWrite=0 in BRANCH, and the instruction still takes 3 cycles.
- **LDR sequencing:** 0xE5912004. Expected: 5-cycle sequence MEMADR(ALUSrcB=01)→MEMREAD(AdrSrc=1)→MEMWB(ResultSrc=01, RegWrite=1).
- **Conditional STR:** 0x15812000 with Z=1. Expected: MEMWRITE asserts AdrSrc=1 and MemWrite=0.
- **ANDS carry preserve:** Flags=0010, ANDS with ALUFlags=1101. Expected: Flags=1110 (NZ updated, C and V preserved).
- **Async reset:** Reset pulsed in MEMWRITE between clock edges. Expected: MemWrite drops immediately, State=FETCH, Flags=0000.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, ALU op codes,
// condition codes and datapath mux encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    localparam logic [3:0] FUNCT_AND = 4'b0000;
    localparam logic [3:0] FUNCT_EOR = 4'b0001;
    localparam logic [3:0] FUNCT_SUB = 4'b0010;
    localparam logic [3:0] FUNCT_ADD = 4'b0100;
    localparam logic [3:0] FUNCT_CMP = 4'b1010;
    localparam logic [3:0] FUNCT_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/cond_logic.sv
// NZCV flag register with per-half write gating, and CondEx evaluation of the
// instruction's Cond field against the registered flags.
module cond_logic
    import mc_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       FlagUpd,
    output logic       CondEx
);

    logic [3:0] flags_q, flags_d;
    logic       upd_q, upd_d;
    logic       held_q, held_d;
    logic       cond_now;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_q;

    always_comb begin
        cond_now = 1'b0;
        case (Cond)
            COND_EQ: cond_now = z;
            COND_NE: cond_now = ~z;
            COND_CS: cond_now = c;
            COND_CC: cond_now = ~c;
            COND_MI: cond_now = n;
            COND_PL: cond_now = ~n;
            COND_VS: cond_now = v;
            COND_VC: cond_now = ~v;
            COND_HI: cond_now = c & ~z;
            COND_LS: cond_now = ~c | z;
            COND_GE: cond_now = (n == v);
            COND_LT: cond_now = (n != v);
            COND_GT: cond_now = ~z & (n == v);
            COND_LE: cond_now = z | (n != v);
            COND_AL: cond_now = 1'b1;
            default: cond_now = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (FlagUpd && cond_now) begin
            if (FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
            if (FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
        end
        upd_d  = FlagUpd;
        held_d = cond_now;
    end

    // The cycle after a flag update still belongs to the same instruction, so it
    // sees the CondEx computed from the flags as they were before the update.
    assign CondEx = upd_q ? held_q : cond_now;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            flags_q <= 4'b0000;
            upd_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            flags_q <= flags_d;
            upd_q   <= upd_d;
            held_q  <= held_d;
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM for the ARM-subset datapath: sequences fetch, decode,
// memory, ALU and branch steps and decodes Funct into ALU control and flag writes.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int HAS_CMP    = 1
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [31:0]           Instr,
    input  logic [3:0]            ALUFlags,
    output logic                  PCWrite,
    output logic                  IRWrite,
    output logic                  MemWrite,
    output logic                  RegWrite,
    output logic                  AdrSrc,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [1:0]            RegSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic [3:0]            State
);

    state_t     state_q, state_d;
    logic [1:0] op;
    logic       i_bit, s_bit;
    logic [3:0] funct;
    logic [2:0] alu_op, alu_sel;
    logic       no_write;
    logic [1:0] flag_w;
    logic       flag_upd;
    logic       cond_ex;
    logic       pc_w, ir_w, mem_w, reg_w;
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign i_bit        = Instr[25];
    assign funct        = Instr[24:21];
    assign s_bit        = Instr[20];
    assign unused_instr = ^Instr[19:0];

    always_comb begin
        alu_op   = ALU_ADD;
        no_write = 1'b0;
        flag_w   = 2'b00;
        case (funct)
            FUNCT_ADD: begin alu_op = ALU_ADD; flag_w = {s_bit, s_bit}; end
            FUNCT_SUB: begin alu_op = ALU_SUB; flag_w = {s_bit, s_bit}; end
            FUNCT_AND: begin alu_op = ALU_AND; flag_w = {s_bit, 1'b0};  end
            FUNCT_ORR: begin alu_op = ALU_ORR; flag_w = {s_bit, 1'b0};  end
            FUNCT_EOR: begin alu_op = ALU_EOR; flag_w = {s_bit, 1'b0};  end
            FUNCT_CMP: begin
                if ((HAS_CMP != 0) && s_bit) begin
                    alu_op = ALU_SUB;
                    flag_w = 2'b11;
                end
                no_write = 1'b1;
            end
            default: no_write = 1'b1;
        endcase
    end

    cond_logic u_cond (
        .CLK      (CLK),
        .Reset    (Reset),
        .Cond     (Instr[31:28]),
        .ALUFlags (ALUFlags),
        .FlagW    (flag_w),
        .FlagUpd  (flag_upd),
        .CondEx   (cond_ex)
    );

    always_comb begin
        state_d   = state_q;
        pc_w      = 1'b0;
        ir_w      = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_sel   = ALU_ADD;
        flag_upd  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_w      = 1'b1;
                pc_w      = 1'b1;
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (op)
                    2'b00:   state_d = i_bit ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = s_bit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = cond_ex;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc  = 1'b1;
                mem_w   = cond_ex;
                state_d = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = (state_q == S_EXECUTEI) ? SRCB_IMM : SRCB_RD2;
                alu_sel  = alu_op;
                flag_upd = 1'b1;
                state_d  = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_w     = cond_ex & ~no_write;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_ALUOUT;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                pc_w      = cond_ex;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Enables are gated directly by Reset so they drop between clock edges.
    assign PCWrite    = pc_w  & ~Reset;
    assign IRWrite    = ir_w  & ~Reset;
    assign MemWrite   = mem_w & ~Reset;
    assign RegWrite   = reg_w & ~Reset;
    assign ImmSrc     = op;
    assign RegSrc     = {(op == 2'b01) & ~s_bit, op == 2'b10};
    assign ALUControl = ALU_CTRL_W'(alu_sel);
    assign State      = state_q;

endmodule
